// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader FSM state encoding and the word-packing geometry.
package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive channel plus instruction-memory write bus.
// The loader is the slave; the byte sender / memory side is the master.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// word_full_o flags, combinationally, the byte that completes the current word.
module imem_word_packer
  import rv_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_en_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_en_i) begin
      word_d[8*idx_q +: 8] = byte_i;
      idx_d                = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = byte_en_i && !clear_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image into instruction memory and holds the
// core in reset until the whole image has been written.
module imem_loader
  import rv_loader_pkg::*;
#(
  parameter int          ADDR_W         = 16,
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  imem_loader_if.slave  bus,
  output logic          core_reset_n_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [15:0]   word_count_o
);

  loader_state_t     state_q, state_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [15:0]       word_count_q, word_count_d;
  logic [7:0]        n_lo_q, n_lo_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              core_rst_n_q, core_rst_n_d;

  logic        accept;
  logic        loading;
  logic        byte_en;
  logic        pack_clear;
  logic        word_full;
  logic [31:0] word;
  logic [15:0] hdr_n;

  assign accept  = bus.rx_valid && rx_ready_q;
  assign loading = (state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA);
  assign byte_en = accept && (state_q == DATA);
  assign hdr_n   = {bus.rx_data, n_lo_q};

  imem_word_packer u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .byte_i      (bus.rx_data),
    .byte_en_i   (byte_en),
    .clear_i     (pack_clear),
    .word_o      (word),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    word_count_d = word_count_q;
    n_lo_d       = n_lo_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    pack_clear   = 1'b0;

    if (loading) tmo_d = accept ? 32'd0 : tmo_q + 32'd1;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d    = HDR_LO;
          word_idx_d = '0;
          tmo_d      = '0;
          pack_clear = 1'b1;
        end
      end
      HDR_LO: if (accept) begin
        n_lo_d  = bus.rx_data;
        state_d = HDR_HI;
      end
      HDR_HI: if (accept) begin
        word_count_d = hdr_n;
        state_d = (hdr_n == 16'd0 || 32'(hdr_n) > DEPTH_WORDS) ? ERROR : DATA;
      end
      DATA: if (word_full) begin
        state_d = WRITE;
        addr_d  = ADDR_W'(32'(word_idx_q) << WORD_ADDR_SHIFT);
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_d == word_count_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase

    // Silence timeout wins over everything; any half-built word is dropped.
    if (loading && !accept && TIMEOUT_CYCLES != 0 && tmo_d == TIMEOUT_CYCLES) begin
      state_d    = ERROR;
      pack_clear = 1'b1;
    end

    rx_ready_d   = (state_d == HDR_LO) || (state_d == HDR_HI) || (state_d == DATA);
    busy_d       = rx_ready_d || (state_d == WRITE);
    we_d         = (state_d == WRITE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
    core_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      word_count_q <= '0;
      n_lo_q       <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      rx_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      word_count_q <= word_count_d;
      n_lo_q       <= n_lo_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      rx_ready_q   <= rx_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign core_reset_n_o = core_rst_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, gapped stream, bad headers,
// silence timeout, reload from DONE and asynchronous reset mid-load.
module tb_imem_loader;
  import rv_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        core_reset_n_o, busy_o, done_o, error_o;
  logic [15:0] word_count_o;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader_if #(.ADDR_W(16)) bus ();

  imem_loader #(
    .ADDR_W(16), .DEPTH_WORDS(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .bus            (bus.slave),
    .core_reset_n_o (core_reset_n_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .word_count_o   (word_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe is logged, and the loader must not be ready then.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa_q.push_back(bus.imem_addr);
      wd_q.push_back(bus.imem_wdata);
      wr_cnt++;
      $display("[TB] write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
      chk("rx_ready_in_write", {31'b0, bus.rx_ready}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rx_ready_wait", {31'b0, bus.rx_ready}, 32'd1);
    @(posedge clk);
    $display("[TB] byte %h accepted", b);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_image(input int max_gap);
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(img[i], $urandom_range(0, max_gap));
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk({tag, "_a0"}, 32'(wa_q[0]), 32'h0000);
      chk({tag, "_d0"}, wd_q[0], 32'h00A00513);
      chk({tag, "_a1"}, 32'(wa_q[1]), 32'h0004);
      chk({tag, "_d1"}, wd_q[1], 32'h00100593);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    reset_i      = 1'b0;
    start_i      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values
    #1;
    chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    chk("rst_we", {31'b0, bus.imem_we}, 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_core_rst_n", {31'b0, core_reset_n_o}, 32'd0);
    chk("rst_busy_done_err", {29'b0, busy_o, done_o, error_o}, 32'd0);
    chk("rst_word_count", 32'(word_count_o), 32'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;

    // Normal back-to-back load
    pulse_start();
    chk("start_busy", {31'b0, busy_o}, 32'd1);
    send_image(0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("last_we", {31'b0, bus.imem_we}, 32'd1);
    chk("last_done_early", {31'b0, done_o}, 32'd0);
    @(negedge clk);
    chk("done", {31'b0, done_o}, 32'd1);
    chk("core_rst_n_done", {31'b0, core_reset_n_o}, 32'd1);
    chk("word_count", 32'(word_count_o), 32'd2);
    check_writes("normal");

    // Reload from DONE, this time with gaps in the stream
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    chk("reload_core_rst_n", {31'b0, core_reset_n_o}, 32'd0);
    chk("reload_done_clr", {31'b0, done_o}, 32'd0);
    send_image(3);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    chk("gap_done", {31'b0, done_o}, 32'd1);
    check_writes("gap");

    // Header 00 00
    wr_before = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("hdr0_error", {31'b0, error_o}, 32'd1);
    chk("hdr0_core_rst_n", {31'b0, core_reset_n_o}, 32'd0);
    chk("hdr0_busy", {31'b0, busy_o}, 32'd0);
    chk("hdr0_nwr", 32'(wr_cnt - wr_before), 32'd0);

    // Header 01 01 (N = 257)
    pulse_start();
    chk("err_clr_on_start", {31'b0, error_o}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("hdr257_error", {31'b0, error_o}, 32'd1);
    chk("hdr257_core_rst_n", {31'b0, core_reset_n_o}, 32'd0);
    chk("hdr257_word_count", 32'(word_count_o), 32'h0101);
    chk("hdr257_nwr", 32'(wr_cnt - wr_before), 32'd0);

    // Silence timeout: one-word header, two data bytes, then nothing
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("tmo_before_error", {31'b0, error_o}, 32'd0);
    chk("tmo_before_busy", {31'b0, busy_o}, 32'd1);
    @(negedge clk);
    chk("tmo_error", {31'b0, error_o}, 32'd1);
    chk("tmo_busy", {31'b0, busy_o}, 32'd0);
    chk("tmo_nwr", 32'(wr_cnt - wr_before), 32'd0);

    // Asynchronous reset in the middle of DATA
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("mid_busy", {31'b0, busy_o}, 32'd1);
    reset_i = 1'b0;
    #1;
    chk("arst_busy_done_err", {29'b0, busy_o, done_o, error_o}, 32'd0);
    chk("arst_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    chk("arst_wdata", bus.imem_wdata, 32'd0);
    chk("arst_addr", 32'(bus.imem_addr), 32'd0);
    chk("arst_word_count", 32'(word_count_o), 32'd0);
    chk("arst_core_rst_n", {31'b0, core_reset_n_o}, 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer that fills the instruction memory, which the core only ever reads, before the core runs.
- Receives a length-prefixed program image over a valid/ready byte interface and packs bytes into little-endian 32-bit words.
- Issues one write per word at byte addresses 0, 4, 8, and so on.
- Holds the core in reset until the image is loaded; releases it on completion.

Parameters:
- ADDR_W, 16, width of the instruction-memory byte address.
- DEPTH_WORDS, 256, instruction-memory capacity in words; the legal header range is 1..DEPTH_WORDS.
- TIMEOUT_CYCLES, 1000000, maximum number of cycles without an accepted byte while loading; 0 disables the timeout.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  reset; one clock domain, asynchronous, active-low.
- start_i  input  1  load request; sampled only in IDLE, DONE and ERROR.
- rx_data_i  input  8  incoming byte.
- rx_valid_i  input  1  rx_data_i is valid.
- rx_ready_o  output  1  loader can accept a byte.
- imem_we_o  output  1  one-cycle instruction-memory write strobe.
- imem_addr_o  output  ADDR_W  byte address of the write; always word aligned.
- imem_wdata_o  output  32  assembled instruction word.
- core_reset_n_o  output  1  active-low reset to the core.
- busy_o  output  1  load in progress.
- done_o  output  1  image loaded.
- error_o  output  1  load aborted.
- word_count_o  output  16  header word count N, latched.

Behaviour:
- Reset values:
  - state = IDLE.
  - rx_ready_o, imem_we_o, busy_o, done_o and error_o = 0.
  - imem_addr_o = 0, imem_wdata_o = 0, word_count_o = 0.
  - core_reset_n_o = 0; the core is held in reset after power-on.
- Handshake:
  - A byte is accepted only on a cycle where rx_valid_i and rx_ready_o are both 1.
  - rx_ready_o = 1 only in HDR_LO, HDR_HI and DATA.
  - The loader places no requirement on the sender holding rx_data_i across cycles without acceptance.
- FSM transitions:
  - IDLE: start_i -> HDR_LO; clear the word index, byte index and timeout counter.
  - HDR_LO: accept a byte -> it becomes N[7:0]; go to HDR_HI.
  - HDR_HI: accept a byte -> it becomes N[15:8] and word_count_o is updated. If N==0 or N>DEPTH_WORDS -> ERROR, else -> DATA.
  - DATA: the k-th accepted byte of a word (k=0..3) goes to bits [8k+7:8k]. After k=3 -> WRITE.
  - WRITE (one cycle, rx_ready_o=0):
    - imem_we_o=1, imem_addr_o = word_idx*4 (truncated to ADDR_W), imem_wdata_o = the assembled word.
    - Next cycle: word_idx+1; if it equals N -> DONE, else -> DATA.
  - DONE: done_o=1 and core_reset_n_o=1. start_i -> HDR_LO; core_reset_n_o drops to 0 that same clock edge and done_o clears.
  - ERROR: error_o=1 and core_reset_n_o=0. start_i -> HDR_LO; error_o clears.
- Outputs by state: busy_o=1 in HDR_LO, HDR_HI, DATA and WRITE. imem_we_o is 0 outside WRITE.
- Latency: last byte accepted at edge t -> imem_we_o high in cycle t+1 -> DONE, done_o and core_reset_n_o high from t+2.
- Timeout:
  - The counter increments in HDR_LO, HDR_HI and DATA on every cycle without an accepted byte.
  - It clears on every acceptance.
  - When it reaches TIMEOUT_CYCLES (if nonzero) -> ERROR; a partially assembled word is discarded, and already-written words are not erased.
- start_i while busy_o=1 is ignored.
- Reset asserted mid-load aborts immediately to the reset values; the memory contents already written are untouched.
- Zero-count header: the load never enters DATA.

Decomposition:
- Package rv_loader_pkg holds:
  - the state enum typedef loader_state_t (IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERROR);
  - the constants BYTES_PER_WORD=4 and WORD_ADDR_SHIFT=2.
- Sub-module imem_word_packer, with clk_i and reset_i:
  - inputs byte_i, byte_en_i, clear_i;
  - outputs word_o and word_full_o (after the 4th byte);
  - holds the little-endian shift/insert register and the 2-bit byte index.

Test Plan:
- Normal load. Stimulus: start_i, then bytes 02 00 13 05 A0 00 93 05 10 00.
- Normal load, required response:
  - a write at addr 0x0000 with data 0x00A00513;
  - then a write at addr 0x0004 with data 0x00100593;
  - done_o=1 and core_reset_n_o=1 two cycles after the last byte;
  - word_count_o=2.
- Backpressure/gaps: the same image with rx_valid_i toggled pseudo-randomly -> identical writes. rx_ready_o must be 0 during each WRITE cycle, and no byte may be lost or duplicated.
- Bad headers:
  - header 00 00 -> error_o=1, no imem_we_o pulse, core_reset_n_o=0;
  - header 01 01 (N=257 > 256) -> the same response.
- Timeout (TIMEOUT_CYCLES=16): header 01 00, two data bytes, then silence -> error_o=1 exactly 16 cycles after the last acceptance, and no write issued.
- Reload and reset:
  - from DONE, pulse start_i -> core_reset_n_o=0 on the next cycle and a new load proceeds;
  - assert reset_i low mid-DATA -> all outputs take their reset values asynchronously (before the next clock edge) and the FSM is in IDLE.
